// File: rtl/riscv_mem_arbiter_pkg.sv
// rtl/riscv_mem_arbiter_pkg.sv - shared constants and types for the instruction/data memory arbiter
package riscv_mem_arbiter_pkg;

    // Default widths: byte-address/data width and memory word-address width.
    localparam int DW_DEFAULT     = 32;
    localparam int MEM_AW_DEFAULT = 6;

    // Port identifiers, also the bit positions inside the one-hot grant vector.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Field positions inside the response register {valid, port, we, err}.
    localparam int RSP_ERR   = 0;
    localparam int RSP_WE    = 1;
    localparam int RSP_PORT  = 2;
    localparam int RSP_VALID = 3;
    localparam int RSP_W     = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// rtl/riscv_rr_arb2.sv - two-way round-robin arbiter holding the priority bit
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (priority returns to the data port)
//   en_i   : grants allowed this cycle
//   req_i  : {data request, fetch request}
//   gnt_o  : one-hot grant, same bit order as req_i
import riscv_mem_arbiter_pkg::*;

module riscv_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic r_prio;
    logic w_contested;

    assign w_contested = en_i & req_i[0] & req_i[1];

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (w_contested) begin
                gnt_o = (r_prio == PORT_D) ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Priority moves to the loser only when both ports competed; a lone
    // requester does not disturb the fairness order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio <= PORT_D;
        end else if (w_contested) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one single-port memory between fetch and load/store ports
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   i_req_i/i_addr_i                   : fetch command (read only)
//   i_gnt_o/i_rvalid_o/i_rdata_o/i_err_o : fetch grant and one-cycle response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  : load/store command
//   d_gnt_o/d_rvalid_o/d_rdata_o/d_err_o : load/store grant and one-cycle response
//   mem_addr_o/mem_rd_en_o/mem_wr_en_o/mem_wdata_o/mem_rdata_i : memory side
import riscv_mem_arbiter_pkg::*;

module riscv_mem_arbiter #(
    parameter int DW     = DW_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [DW-1:0]     i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DW-1:0]     i_rdata_o,
    output logic              i_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [DW-1:0]     d_addr_i,
    input  logic [DW-1:0]     d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DW-1:0]     d_rdata_o,
    output logic              d_err_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    logic             r_rst_dly;
    logic [RSP_W-1:0] r_rsp;
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;

    logic             w_allow;
    logic [1:0]       w_gnt;
    logic             w_any;
    logic             w_sel;
    logic [DW-1:0]    w_addr;
    logic             w_we;
    logic             w_err;
    logic             w_issue;
    logic [RSP_W-1:0] w_rsp_d;
    logic             w_live;
    logic             w_rd_ok;
    logic             w_own_i;
    logic             w_own_d;

    // Grants stay off for one extra cycle after reset falls so every output
    // is quiet in the first post-reset cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rst_dly <= 1'b1;
        end else begin
            r_rst_dly <= 1'b0;
        end
    end

    assign w_allow = ~rst_i & ~r_rst_dly;

    riscv_rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_allow),
        .req_i ({d_req_i, i_req_i}),
        .gnt_o (w_gnt)
    );

    assign i_gnt_o = w_gnt[PORT_I];
    assign d_gnt_o = w_gnt[PORT_D];
    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[PORT_D];
    assign w_addr  = w_sel ? d_addr_i : i_addr_i;
    assign w_we    = w_sel & d_we_i;

    // Misaligned or beyond the memory's byte range.
    assign w_err   = (|w_addr[1:0]) | (|w_addr[DW-1:MEM_AW+2]);
    assign w_issue = w_any & ~w_err;

    assign mem_addr_o  = w_issue ? w_addr[MEM_AW+1:2] : '0;
    assign mem_rd_en_o = w_issue & ~w_we;
    assign mem_wr_en_o = w_issue & w_we;
    assign mem_wdata_o = (w_issue & w_we) ? d_wdata_i : '0;

    always_comb begin
        w_rsp_d            = '0;
        w_rsp_d[RSP_VALID] = w_any;
        w_rsp_d[RSP_PORT]  = w_sel;
        w_rsp_d[RSP_WE]    = w_we;
        w_rsp_d[RSP_ERR]   = w_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp   <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_rsp   <= w_rsp_d;
            r_state <= w_state_nxt;
        end
    end

    // RESP never stalls the command side; it only tracks whether a response
    // is due this cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)  w_state_nxt = ST_RESP;
            ST_RESP: if (!w_any) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A response pending when reset arrives is dropped immediately.
    assign w_live  = (r_state == ST_RESP) & r_rsp[RSP_VALID] & ~rst_i;
    assign w_rd_ok = w_live & ~r_rsp[RSP_WE] & ~r_rsp[RSP_ERR];
    assign w_own_i = (r_rsp[RSP_PORT] == PORT_I);
    assign w_own_d = (r_rsp[RSP_PORT] == PORT_D);

    assign i_rvalid_o = w_live & w_own_i;
    assign i_err_o    = w_live & w_own_i & r_rsp[RSP_ERR];
    assign i_rdata_o  = (w_rd_ok & w_own_i) ? mem_rdata_i : '0;

    assign d_rvalid_o = w_live & w_own_d;
    assign d_err_o    = w_live & w_own_d & r_rsp[RSP_ERR];
    assign d_rdata_o  = (w_rd_ok & w_own_d) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req, d_req, d_we;
    logic [DW-1:0] i_addr, d_addr, d_wdata;
    logic          i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [DW-1:0] i_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] bmem    [NW];
    logic [DW-1:0] ref_mem [NW];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.DW(DW), .MEM_AW(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .i_req_i     (i_req),
        .i_addr_i    (i_addr),
        .i_gnt_o     (i_gnt),
        .i_rvalid_o  (i_rvalid),
        .i_rdata_o   (i_rdata),
        .i_err_o     (i_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem_addr_o  (mem_addr),
        .mem_rd_en_o (mem_rd_en),
        .mem_wr_en_o (mem_wr_en),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Synchronous single-port memory seen by the DUT.
    always @(posedge clk) begin
        if (mem_wr_en) bmem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= bmem[mem_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rule, address legality and a shadow memory.
    logic          m_prio  = 1'b1;
    logic          m_block = 1'b1;
    logic          p_valid = 1'b0;
    logic          p_port  = 1'b0;
    logic          p_we    = 1'b0;
    logic          p_err   = 1'b0;
    logic [DW-1:0] p_data  = '0;

    always @(negedge clk) begin : model
        logic          ei, ed, contested, anyg, we, bad, live, issue;
        logic [DW-1:0] a, nd;
        ei = 1'b0;
        ed = 1'b0;
        contested = !(rst || m_block) && i_req && d_req;
        if (!(rst || m_block)) begin
            if (contested) begin
                if (m_prio) ed = 1'b1; else ei = 1'b1;
            end else begin
                ei = i_req;
                ed = d_req;
            end
        end
        anyg  = ei || ed;
        a     = ed ? d_addr : i_addr;
        we    = ed && d_we;
        bad   = (a % 4 != 0) || (a >= 4 * NW);
        issue = anyg && !bad;

        chk("i_gnt", i_gnt, ei);
        chk("d_gnt", d_gnt, ed);
        chk("mem_rd_en", mem_rd_en, issue && !we);
        chk("mem_wr_en", mem_wr_en, issue && we);
        chk("mem_addr", mem_addr, issue ? a / 4 : 0);
        chk("mem_wdata", mem_wdata, (issue && we) ? d_wdata : 0);

        live = p_valid && !rst;
        chk("i_rvalid", i_rvalid, live && !p_port);
        chk("i_err", i_err, live && !p_port && p_err);
        chk("i_rdata", i_rdata, (live && !p_port && !p_we && !p_err) ? p_data : 0);
        chk("d_rvalid", d_rvalid, live && p_port);
        chk("d_err", d_err, live && p_port && p_err);
        chk("d_rdata", d_rdata, (live && p_port && !p_we && !p_err) ? p_data : 0);

        nd = '0;
        if (issue && !we) nd = ref_mem[a / 4];
        if (issue && we) ref_mem[a / 4] = d_wdata;
        p_valid = anyg;
        p_port  = ed;
        p_we    = we;
        p_err   = bad;
        p_data  = nd;
        if (rst) m_prio = 1'b1;
        else if (contested) m_prio = !m_prio;
        m_block = rst;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ni, nd;
        logic exp_d;
        for (int i = 0; i < NW; i++) begin
            bmem[i]    = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        bmem[2]    = 32'h0050_0093;
        ref_mem[2] = 32'h0050_0093;

        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = '0;
        rst = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_rvalid", i_rvalid | d_rvalid, 0);

        // First cycle after release: still quiet.
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rel_i_gnt", i_gnt, 0);
        chk("rel_d_gnt", d_gnt, 0);
        chk("rel_strobe", mem_rd_en | mem_wr_en, 0);

        // Both request every cycle: D first, then strict alternation.
        ni = 0; nd = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            i_addr = 4 * ni;
            d_addr = 32'h40 + 4 * nd;
            @(negedge clk);
            exp_d = (k % 2 == 0);
            chk("alt_d_gnt", d_gnt, exp_d);
            chk("alt_i_gnt", i_gnt, !exp_d);
            if (k > 0) chk("alt_rsp_port", exp_d ? i_rvalid : d_rvalid, 1);
            if (k == 1) chk("alt_d_rdata", d_rdata, 32'hA500_0010);
            if (k == 2) chk("alt_i_rdata", i_rdata, 32'hA500_0000);
            if (exp_d) nd++; else ni++;
        end

        // Fetch only.
        cyc(); i_req = 1'b1; i_addr = 32'h8; d_req = 1'b0;
        @(negedge clk);
        chk("f_gnt", i_gnt, 1);
        chk("f_addr", mem_addr, 2);
        chk("f_rd_en", mem_rd_en, 1);
        cyc(); i_req = 1'b0;
        @(negedge clk);
        chk("f_rvalid", i_rvalid, 1);
        chk("f_rdata", i_rdata, 32'h0050_0093);
        chk("f_err", i_err, 0);

        // Store then load of the same word.
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_wr_en", mem_wr_en, 1);
        chk("st_addr", mem_addr, 4);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        chk("st_rvalid", d_rvalid, 1);
        chk("st_rdata", d_rdata, 0);
        chk("ld_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0;
        @(negedge clk);
        chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);

        // Misaligned and out-of-range loads, then a misaligned store.
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h13;
        @(negedge clk);
        chk("mis_gnt", d_gnt, 1);
        chk("mis_strobe", mem_rd_en | mem_wr_en, 0);
        cyc(); d_addr = 32'h100;
        @(negedge clk);
        chk("mis_err", d_err, 1);
        chk("mis_rdata", d_rdata, 0);
        chk("oor_strobe", mem_rd_en | mem_wr_en, 0);
        cyc(); d_we = 1'b1; d_addr = 32'h2; d_wdata = 32'h1234;
        @(negedge clk);
        chk("oor_err", d_err, 1);
        chk("mst_wr_en", mem_wr_en, 0);
        cyc(); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("mst_err", d_err, 1);

        // Contested fetch loses and is dropped: no trace.
        cyc(); i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h8;
        @(negedge clk);
        chk("drop_i_gnt", i_gnt, 0);
        cyc(); i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("drop_i_rvalid", i_rvalid, 0);

        // Reset right after a granted load.
        cyc(); d_req = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        chk("rr_gnt", d_gnt, 1);
        cyc(); rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rr_rvalid", d_rvalid, 0);
        chk("rr_rdata", d_rdata, 0);
        cyc(); d_req = 1'b1; d_addr = 32'h24;
        @(negedge clk);
        chk("rr_gnt_rst", d_gnt, 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rr_rel_gnt", d_gnt, 0);
        chk("rr_rel_rvalid", d_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("rr_gnt2", d_gnt, 1);
        cyc(); d_req = 1'b0;
        @(negedge clk);
        chk("rr_rvalid2", d_rvalid, 1);

        // Mixed traffic checked by the model alone.
        for (int k = 0; k < 60; k++) begin
            cyc();
            i_req   = $urandom_range(0, 1);
            d_req   = $urandom_range(0, 1);
            d_we    = $urandom_range(0, 1);
            i_addr  = 4 * $urandom_range(0, 70);
            d_addr  = 4 * $urandom_range(0, 70);
            if ($urandom_range(0, 7) == 0) d_addr = d_addr + 1;
            d_wdata = $urandom;
        end
        cyc(); i_req = 1'b0; d_req = 1'b0;
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
